// File: rtl/pma_uncached_arb_if.sv
// Uncached-port bundle for pma_uncached_arb: two requesters, shared
// response bus, and the downstream uncached memory port.
interface pma_uncached_arb_if #(
  parameter int abits = 48
);
  logic             i_req0_valid;
  logic             o_req0_ready;
  logic [abits-1:0] i_req0_addr;
  logic             i_req1_valid;
  logic             o_req1_ready;
  logic [abits-1:0] i_req1_addr;
  logic             i_req1_write;
  logic [63:0]      i_req1_wdata;
  logic [7:0]       i_req1_wstrb;
  logic             o_resp0_valid;
  logic             o_resp1_valid;
  logic [63:0]      o_resp_data;
  logic             o_resp_err;
  logic             o_mem_req_valid;
  logic             i_mem_req_ready;
  logic [abits-1:0] o_mem_req_addr;
  logic             o_mem_req_write;
  logic [63:0]      o_mem_req_wdata;
  logic [7:0]       o_mem_req_wstrb;
  logic             i_mem_resp_valid;
  logic [63:0]      i_mem_resp_data;
  logic             i_mem_resp_err;

  // arbiter side
  modport slave (
    input  i_req0_valid, i_req0_addr,
    input  i_req1_valid, i_req1_addr, i_req1_write, i_req1_wdata, i_req1_wstrb,
    input  i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data, i_mem_resp_err,
    output o_req0_ready, o_req1_ready, o_resp0_valid, o_resp1_valid,
    output o_resp_data, o_resp_err,
    output o_mem_req_valid, o_mem_req_addr, o_mem_req_write,
    output o_mem_req_wdata, o_mem_req_wstrb
  );

  // requester / memory model side
  modport master (
    output i_req0_valid, i_req0_addr,
    output i_req1_valid, i_req1_addr, i_req1_write, i_req1_wdata, i_req1_wstrb,
    output i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data, i_mem_resp_err,
    input  o_req0_ready, o_req1_ready, o_resp0_valid, o_resp1_valid,
    input  o_resp_data, o_resp_err,
    input  o_mem_req_valid, o_mem_req_addr, o_mem_req_write,
    input  o_mem_req_wdata, o_mem_req_wstrb
  );
endinterface

// File: rtl/pma_uncached_arb.sv
// Round-robin arbiter for uncached (IO) accesses from the instruction (0)
// and data (1) paths onto one uncached memory port. Addresses outside the
// CLINT/PLIC/IO1 regions complete locally with an error.
// Optional watchdog: define PMA_UNCACHED_TIMEOUT_EN.
module pma_uncached_arb #(
  parameter int abits          = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              i_clk,
  input logic              i_nrst,
  pma_uncached_arb_if.slave bus
);
  localparam logic [abits-1:0] CLINT_BAR  = abits'(64'h0200_0000);
  localparam logic [abits-1:0] CLINT_MASK = abits'(64'h0000_ffff);
  localparam logic [abits-1:0] PLIC_BAR   = abits'(64'h0c00_0000);
  localparam logic [abits-1:0] PLIC_MASK  = abits'(64'h03ff_ffff);
  localparam logic [abits-1:0] IO1_BAR    = abits'(64'h1000_0000);
  localparam logic [abits-1:0] IO1_MASK   = abits'(64'h000f_ffff);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant, idx_q;
  logic [abits-1:0] addr_q;
  logic             write_q;
  logic [63:0]      wdata_q;
  logic [7:0]       wstrb_q;
  logic [63:0]      rdata_q;
  logic             rerr_q;

  logic             any_valid, grant, accept, sel_hit, tmo, tmo_fire;
  logic [abits-1:0] sel_addr;

  function automatic logic region_hit(input logic [abits-1:0] a);
    return ((a & ~CLINT_MASK) == CLINT_BAR) ||
           ((a & ~PLIC_MASK)  == PLIC_BAR)  ||
           ((a & ~IO1_MASK)   == IO1_BAR);
  endfunction

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    any_valid = bus.i_req0_valid | bus.i_req1_valid;
    grant     = (bus.i_req0_valid & bus.i_req1_valid) ? ~last_grant : bus.i_req1_valid;
    sel_addr  = grant ? bus.i_req1_addr : bus.i_req0_addr;
    sel_hit   = region_hit(sel_addr);
    accept    = (state == IDLE) & any_valid;
  end

`ifdef PMA_UNCACHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt;

  // Watchdog: cleared entering REQ, counts through REQ and WAIT_RESP
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                                cnt <= '0;
    else if (state_nxt == REQ && state != REQ)  cnt <= '0;
    else if (state == REQ || state == WAIT_RESP) cnt <= cnt + 1'b1;
  end

  assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake outputs; progress beats the watchdog
  always_comb begin
    state_nxt          = state;
    tmo_fire           = 1'b0;
    bus.o_req0_ready   = 1'b0;
    bus.o_req1_ready   = 1'b0;
    bus.o_mem_req_valid = 1'b0;
    bus.o_resp0_valid  = 1'b0;
    bus.o_resp1_valid  = 1'b0;
    case (state)
      IDLE: begin
        bus.o_req0_ready = i_nrst & any_valid & ~grant;
        bus.o_req1_ready = i_nrst & any_valid & grant;
        if (any_valid) state_nxt = sel_hit ? REQ : RESP;
      end
      REQ: begin
        bus.o_mem_req_valid = 1'b1;
        if (bus.i_mem_req_ready) state_nxt = WAIT_RESP;
        else if (tmo) begin
          state_nxt = RESP;
          tmo_fire  = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (bus.i_mem_resp_valid) state_nxt = RESP;
        else if (tmo) begin
          state_nxt = RESP;
          tmo_fire  = 1'b1;
        end
      end
      RESP: begin
        bus.o_resp0_valid = ~idx_q;
        bus.o_resp1_valid = idx_q;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch on accept; response data/err captured from memory,
  // region miss or watchdog expiry
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      last_grant <= 1'b1;
      idx_q      <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        idx_q      <= grant;
        addr_q     <= sel_addr;
        write_q    <= grant & bus.i_req1_write;
        wdata_q    <= grant ? bus.i_req1_wdata : 64'd0;
        wstrb_q    <= grant ? bus.i_req1_wstrb : 8'd0;
        if (!sel_hit) begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end
      end
      if (state == WAIT_RESP && bus.i_mem_resp_valid) begin
        rdata_q <= bus.i_mem_resp_data;
        rerr_q  <= bus.i_mem_resp_err;
      end else if (tmo_fire) begin
        rdata_q <= '0;
        rerr_q  <= 1'b1;
      end
    end
  end

  assign bus.o_mem_req_addr  = addr_q;
  assign bus.o_mem_req_write = write_q;
  assign bus.o_mem_req_wdata = wdata_q;
  assign bus.o_mem_req_wstrb = wstrb_q;
  assign bus.o_resp_data     = rdata_q;
  assign bus.o_resp_err      = rerr_q;
endmodule

// File: tb/tb_pma_uncached_arb.sv
// Directed bench for pma_uncached_arb: table of single transactions plus
// sequences for round-robin, REQ stall, mid-transaction reset and the
// no-response wait (watchdog when PMA_UNCACHED_TIMEOUT_EN is defined).
module tb_pma_uncached_arb;
  logic i_clk = 1'b0;
  logic i_nrst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  pma_uncached_arb_if #(.abits(48)) bus ();

  pma_uncached_arb #(.abits(48), .TIMEOUT_CYCLES(16)) dut (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        req1;
    logic [47:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] mdata;
    logic        merr;
    logic        hit;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to 2ns after the next rising edge
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.i_req0_valid = 0; bus.i_req0_addr = '0;
    bus.i_req1_valid = 0; bus.i_req1_addr = '0; bus.i_req1_write = 0;
    bus.i_req1_wdata = '0; bus.i_req1_wstrb = '0;
    bus.i_mem_req_ready = 0; bus.i_mem_resp_valid = 0;
    bus.i_mem_resp_data = '0; bus.i_mem_resp_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_nrst = 0;
    step(); step();
    i_nrst = 1;
    step();
  endtask

  // One transaction from an idle arbiter with a memory that accepts at once
  task automatic run_txn(input vec_t v, input string tag);
    if (v.req1) begin
      bus.i_req1_valid = 1; bus.i_req1_addr = v.addr; bus.i_req1_write = v.wr;
      bus.i_req1_wdata = v.wdata; bus.i_req1_wstrb = v.wstrb;
    end else begin
      bus.i_req0_valid = 1; bus.i_req0_addr = v.addr;
    end
    #1;
    chk({tag, " ready"}, v.req1 ? bus.o_req1_ready : bus.o_req0_ready, 1);
    step();
    bus.i_req0_valid = 0; bus.i_req1_valid = 0;
    if (v.hit) begin
      #1;
      chk({tag, " mem_valid"}, bus.o_mem_req_valid, 1);
      chk({tag, " mem_addr"}, bus.o_mem_req_addr, v.addr);
      chk({tag, " mem_write"}, bus.o_mem_req_write, v.req1 ? v.wr : 1'b0);
      chk({tag, " mem_wstrb"}, bus.o_mem_req_wstrb, v.req1 ? v.wstrb : 8'h0);
      if (v.req1) chk({tag, " mem_wdata"}, bus.o_mem_req_wdata, v.wdata);
      bus.i_mem_req_ready = 1;
      step();
      bus.i_mem_req_ready = 0;
      #1;
      chk({tag, " mem_valid drop"}, bus.o_mem_req_valid, 0);
      bus.i_mem_resp_valid = 1; bus.i_mem_resp_data = v.mdata; bus.i_mem_resp_err = v.merr;
      step();
      bus.i_mem_resp_valid = 0;
    end else begin
      #1;
      chk({tag, " no mem_valid"}, bus.o_mem_req_valid, 0);
    end
    #1;
    chk({tag, " resp_mine"}, v.req1 ? bus.o_resp1_valid : bus.o_resp0_valid, 1);
    chk({tag, " resp_other"}, v.req1 ? bus.o_resp0_valid : bus.o_resp1_valid, 0);
    chk({tag, " data"}, bus.o_resp_data, v.hit ? v.mdata : 64'h0);
    chk({tag, " err"}, bus.o_resp_err, v.hit ? v.merr : 1'b1);
    step();
    #1;
    chk({tag, " pulse end"}, {bus.o_resp0_valid, bus.o_resp1_valid}, 0);
  endtask

  vec_t vecs[13];
  bit   tmo_en;

  initial begin
`ifdef PMA_UNCACHED_TIMEOUT_EN
    tmo_en = 1;
`else
    tmo_en = 0;
`endif
    vecs[0]  = '{1, 48'h0000_0200_0008, 0, 64'h0, 8'h00, 64'h1122334455667788, 0, 1};
    vecs[1]  = '{0, 48'h0000_8000_0000, 0, 64'h0, 8'h00, 64'h0, 0, 0};
    vecs[2]  = '{0, 48'h0000_0200_ffff, 0, 64'h0, 8'h00, 64'ha5a5a5a5a5a5a5a5, 0, 1};
    vecs[3]  = '{1, 48'h0000_0201_0000, 1, 64'h1234, 8'hff, 64'h9, 0, 0};
    vecs[4]  = '{1, 48'h0000_01ff_ffff, 0, 64'h0, 8'h00, 64'h9, 0, 0};
    vecs[5]  = '{0, 48'h0000_0c00_0000, 0, 64'h0, 8'h00, 64'h0123456789abcdef, 0, 1};
    vecs[6]  = '{1, 48'h0000_0fff_ffff, 1, 64'hcafe0000, 8'hf0, 64'h00000000feedf00d, 1, 1};
    vecs[7]  = '{0, 48'h0000_1000_0000, 0, 64'h0, 8'h00, 64'h42, 0, 1};
    vecs[8]  = '{1, 48'h0000_100f_ffff, 0, 64'h0, 8'h00, 64'h8000000000000001, 0, 1};
    vecs[9]  = '{1, 48'h0000_1010_0000, 0, 64'h0, 8'h00, 64'h9, 0, 0};
    vecs[10] = '{0, 48'h0001_0200_0000, 0, 64'h0, 8'h00, 64'h9, 0, 0};
    vecs[11] = '{1, 48'h8000_1000_0000, 1, 64'h77, 8'h01, 64'h9, 0, 0};
    vecs[12] = '{0, 48'h0000_0200_0010, 0, 64'h0, 8'h00, 64'hdeadbeefcafef00d, 0, 1};

    // reset state
    clear_inputs();
    i_nrst = 0;
    #3;
    chk("rst mem_valid", bus.o_mem_req_valid, 0);
    chk("rst resp", {bus.o_resp0_valid, bus.o_resp1_valid}, 0);
    chk("rst ready", {bus.o_req0_ready, bus.o_req1_ready}, 0);
    chk("rst data", bus.o_resp_data, 0);
    chk("rst err", bus.o_resp_err, 0);
    chk("rst addr", bus.o_mem_req_addr, 0);
    step();
    i_nrst = 1;
    step();

    for (int i = 0; i < 13; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // reset during WAIT_RESP: everything drops, no pulse, then normal service
    bus.i_req1_valid = 1; bus.i_req1_addr = 48'h0200_0008;
    step();
    bus.i_req1_valid = 0; bus.i_mem_req_ready = 1;
    step();
    bus.i_mem_req_ready = 0;
    i_nrst = 0;
    #1;
    chk("midrst mem_valid", bus.o_mem_req_valid, 0);
    chk("midrst resp", {bus.o_resp0_valid, bus.o_resp1_valid}, 0);
    chk("midrst data", bus.o_resp_data, 0);
    chk("midrst err", bus.o_resp_err, 0);
    chk("midrst addr", bus.o_mem_req_addr, 0);
    bus.i_mem_resp_valid = 1; bus.i_mem_resp_data = 64'h99;
    step();
    bus.i_mem_resp_valid = 0;
    i_nrst = 1;
    #1;
    chk("midrst no pulse a", bus.o_resp1_valid, 0);
    step();
    #1;
    chk("midrst no pulse b", bus.o_resp1_valid, 0);
    step();
    run_txn(vecs[0], "after_rst");

    // both continuously valid from reset: grants 0,1,0,1
    do_reset();
    bus.i_req0_valid = 1; bus.i_req0_addr = 48'h1000_0000;
    bus.i_req1_valid = 1; bus.i_req1_addr = 48'h0c00_0004;
    for (int k = 0; k < 4; k++) begin
      bit g;
      g = k[0];
      #1;
      chk($sformatf("rr%0d ready0", k), bus.o_req0_ready, !g);
      chk($sformatf("rr%0d ready1", k), bus.o_req1_ready, g);
      step();
      #1;
      chk($sformatf("rr%0d addr", k), bus.o_mem_req_addr, g ? 48'h0c00_0004 : 48'h1000_0000);
      chk($sformatf("rr%0d busy ready", k), {bus.o_req0_ready, bus.o_req1_ready}, 0);
      bus.i_mem_req_ready = 1;
      step();
      bus.i_mem_req_ready = 0;
      bus.i_mem_resp_valid = 1; bus.i_mem_resp_data = 64'(k + 16);
      step();
      bus.i_mem_resp_valid = 0;
      #1;
      chk($sformatf("rr%0d resp0", k), bus.o_resp0_valid, !g);
      chk($sformatf("rr%0d resp1", k), bus.o_resp1_valid, g);
      chk($sformatf("rr%0d data", k), bus.o_resp_data, 64'(k + 16));
      step();
    end
    bus.i_req0_valid = 0; bus.i_req1_valid = 0;
    step();

    // write held in REQ for 5 cycles; stray memory response ignored;
    // requester 0 waits with valid held, then gets its miss error
    bus.i_req1_valid = 1; bus.i_req1_addr = 48'h1000_0010; bus.i_req1_write = 1;
    bus.i_req1_wdata = 64'hdead; bus.i_req1_wstrb = 8'h03;
    #1;
    chk("stall ready1", bus.o_req1_ready, 1);
    step();
    bus.i_req1_valid = 0;
    bus.i_req0_valid = 1; bus.i_req0_addr = 48'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      bus.i_mem_resp_valid = (i == 2);
      bus.i_mem_resp_data  = 64'hbad;
      #1;
      chk($sformatf("stall%0d valid", i), bus.o_mem_req_valid, 1);
      chk($sformatf("stall%0d addr", i), bus.o_mem_req_addr, 48'h1000_0010);
      chk($sformatf("stall%0d wr", i), bus.o_mem_req_write, 1);
      chk($sformatf("stall%0d wdata", i), bus.o_mem_req_wdata, 64'hdead);
      chk($sformatf("stall%0d wstrb", i), bus.o_mem_req_wstrb, 8'h03);
      chk($sformatf("stall%0d ready", i), {bus.o_req0_ready, bus.o_req1_ready}, 0);
      step();
    end
    bus.i_mem_resp_valid = 0;
    bus.i_mem_req_ready = 1;
    step();
    bus.i_mem_req_ready = 0;
    bus.i_mem_resp_valid = 1; bus.i_mem_resp_data = 64'h55; bus.i_mem_resp_err = 0;
    step();
    bus.i_mem_resp_valid = 0;
    #1;
    chk("stall resp1", bus.o_resp1_valid, 1);
    chk("stall data", bus.o_resp_data, 64'h55);
    chk("stall resp ready0", bus.o_req0_ready, 0);
    step();
    #1;
    chk("queued ready0", bus.o_req0_ready, 1);
    step();
    bus.i_req0_valid = 0;
    #1;
    chk("queued resp0", bus.o_resp0_valid, 1);
    chk("queued err", bus.o_resp_err, 1);
    chk("queued data", bus.o_resp_data, 0);
    step();

    // memory accepts but never answers in time: watchdog fires at k==17
    // when enabled; otherwise the late response at k==20 is served at k==21
    bus.i_req0_valid = 1; bus.i_req0_addr = 48'h0c00_0004;
    step();
    bus.i_req0_valid = 0; bus.i_mem_req_ready = 1;
    step();
    bus.i_mem_req_ready = 0;
    for (int k = 2; k <= 24; k++) begin
      bit exp_p;
      bus.i_mem_resp_valid = (k == 20);
      bus.i_mem_resp_data  = 64'h77;
      exp_p = tmo_en ? (k == 17) : (k == 21);
      #1;
      chk($sformatf("wait k%0d resp0", k), bus.o_resp0_valid, exp_p);
      if (exp_p) begin
        chk("wait err", bus.o_resp_err, tmo_en);
        chk("wait data", bus.o_resp_data, tmo_en ? 64'h0 : 64'h77);
      end
      step();
    end
    bus.i_mem_resp_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pma_uncached_arb.md
Name: pma_uncached_arb

Overview:
- Arbitrates uncached (IO-space) accesses from the instruction path (requester 0) and the data path (requester 1) onto one shared uncached memory port.
- Checks each address against the physical memory attribute regions CLINT, PLIC and IO1 (BAR/MASK constants from pma_pkg).
- Forwards a matching access to the memory port. A non-matching access completes locally with an error and no bus transaction.
- Sits between the River cache front-ends and the core's uncached bus interface.

Parameters:
- abits, 48 (CFG_CPU_ADDR_BITS): physical address width.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_req0_valid  in  1  requester 0 request
- o_req0_ready  out  1  requester 0 accepted
- i_req0_addr  in  abits  requester 0 address
- i_req1_valid  in  1  requester 1 request
- o_req1_ready  out  1  requester 1 accepted
- i_req1_addr  in  abits  requester 1 address
- i_req1_write  in  1  requester 1 write (requester 0 is read-only)
- i_req1_wdata  in  64  requester 1 write data
- i_req1_wstrb  in  8  requester 1 byte strobes
- o_resp0_valid  out  1  requester 0 response pulse
- o_resp1_valid  out  1  requester 1 response pulse
- o_resp_data  out  64  response data, shared by both requesters
- o_resp_err  out  1  response error
- o_mem_req_valid  out  1  memory request
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  abits  latched address
- o_mem_req_write  out  1  latched write
- o_mem_req_wdata  out  64  latched write data
- o_mem_req_wstrb  out  8  latched strobes
- i_mem_resp_valid  in  1  memory response
- i_mem_resp_data  in  64  memory read data
- i_mem_resp_err  in  1  memory bus error

Behaviour:
- Reset (async, i_nrst=0):
  - state=IDLE, last_grant=1.
  - All outputs 0, latched request fields 0.
  - Reset mid-transaction abandons the transaction. No response is issued.
- Region hit: (addr & ~MASK) == BAR for any of CLINT (2000000/ffff), PLIC (c000000/3ffffff) or IO1 (10000000/fffff). Comparison uses the full abits width.
- Arbitration (combinational, IDLE only):
  - Single valid requester is granted.
  - Both valid: grant the one != last_grant (round-robin). First tie after reset goes to requester 0.
  - o_reqN_ready = (state==IDLE) & grant==N. Ready is 0 in every other state.
- Accept cycle T: latch addr/write/wdata/wstrb and the granted index; update last_grant. Requester 0 latches write=0, wstrb=0.
  - Region hit -> REQ.
  - Region miss -> RESP with err=1, data=0. Response appears at T+1.
- REQ:
  - o_mem_req_valid=1 with the latched fields, held stable until i_mem_req_ready.
  - The cycle i_mem_req_ready=1 -> WAIT_RESP. The earliest memory response is the following cycle.
- WAIT_RESP:
  - On i_mem_resp_valid, register data and err -> RESP.
  - Any i_mem_resp_valid seen outside WAIT_RESP is ignored.
- RESP:
  - One-cycle pulse on o_respN_valid for the latched index only.
  - o_resp_data and o_resp_err are valid in the same cycle. There is no backpressure; requesters must sample the pulse.
  - Next state is IDLE.
- o_resp_data and o_resp_err hold their last values outside RESP. They are meaningful only with a valid pulse.
- Best-case hit latency: accept T, mem req T+1 (ready same cycle), mem resp T+2, requester response T+3.
- One outstanding transaction at a time. A request arriving during a transaction waits with valid held; the requester must not drop or change it.

Optional Feature:
- Macro: PMA_UNCACHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES-1 without progress: go to RESP with err=1, data=0, and drop o_mem_req_valid.
  - A late memory response afterwards is ignored per the rule above.
- Undefined: no counter; the block waits indefinitely in REQ or WAIT_RESP.

Test Plan:
- Req1 read addr 0x2000008, mem ready immediately, resp data 0x1122334455667788 two cycles later -> o_resp1_valid pulse at T+3, data 0x1122334455667788, err=0; o_resp0_valid stays 0.
- Req0 addr 0x80000000 (no region) -> o_mem_req_valid never asserted; o_resp0_valid at T+1 with err=1, data 0.
- Both valid from reset at 0x10000000 and 0xC000004 -> requester 0 served first, requester 1 next; with both continuously valid, grants alternate 0,1,0,1.
- Req1 write 0x10000010, wdata 0xDEAD, wstrb 0x03, mem ready held low 5 cycles -> o_mem_req_* stable all 5 cycles; o_req*_ready=0 throughout.
- i_nrst pulled low during WAIT_RESP -> all outputs 0 immediately; no resp pulse; after release, a new request is served normally.
- With PMA_UNCACHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, memory never responds -> err=1 response 16 cycles after entering REQ; a later i_mem_resp_valid produces no pulse.
